// File: rtl/br_arb_wrr_burst.sv
// Weighted round-robin arbiter with burst locking: one-hot zero-latency grant, owner keeps the
// resource for a whole burst and for up to `weight` bursts per turn. Option: BR_ARB_WRR_BURST_ABORT_EN.
module br_arb_wrr_burst #(
    parameter int NumRequesters = 4,
    parameter int WeightWidth   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumRequesters-1:0]             request,
    input  logic [NumRequesters-1:0]             request_last,
    input  logic [NumRequesters*WeightWidth-1:0] weight,
    input  logic                                 ready,
    output logic [NumRequesters-1:0]             grant,
    output logic                                 locked,
    output logic [NumRequesters-1:0]             owner,
    output logic                                 abort
);

    localparam logic [NumRequesters-1:0] OwnerRst  = {1'b1, {(NumRequesters-1){1'b0}}};
    localparam logic [WeightWidth-1:0]   CreditOne = WeightWidth'(1);

    logic [NumRequesters-1:0] owner_r;
    logic [WeightWidth-1:0]   credit_r;
    logic                     locked_r;
    logic                     abort_r;

    logic [NumRequesters-1:0] owner_n_s;
    logic [WeightWidth-1:0]   credit_n_s;
    logic                     locked_n_s;
    logic                     abort_n_s;

    logic [NumRequesters-1:0] higher_s;
    logic [NumRequesters-1:0] req_hi_s;
    logic [NumRequesters-1:0] rot_grant_s;
    logic [WeightWidth-1:0]   sel_weight_s;
    logic [WeightWidth-1:0]   eff_weight_s;
    logic [WeightWidth-1:0]   credit_base_s;
    logic                     xfer_s;
    logic                     reload_s;
    logic                     last_s;

    function automatic logic [NumRequesters-1:0] lowest_set(input logic [NumRequesters-1:0] vec);
        lowest_set = vec & (~vec + NumRequesters'(1));
    endfunction

    // Rotating priority: requesters above the owner first, then wrap from index 0 (owner last).
    always_comb begin
        logic seen;
        seen     = 1'b0;
        higher_s = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            higher_s[i] = seen;
            seen        = seen | owner_r[i];
        end
        req_hi_s    = request & higher_s;
        rot_grant_s = (req_hi_s != '0) ? lowest_set(req_hi_s) : lowest_set(request);
    end

    // Grant selection: lock, sticky owner while credit remains, else rotation.
    always_comb begin
        if (rst) begin
            grant = '0;
        end else if (locked_r) begin
            grant = owner_r & request;
        end else if (((request & owner_r) != '0) && (credit_r != '0)) begin
            grant = owner_r;
        end else begin
            grant = rot_grant_s;
        end
    end

    // Weight of the granted requester, with zero promoted to one.
    always_comb begin
        sel_weight_s = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            sel_weight_s = sel_weight_s | (weight[i*WeightWidth +: WeightWidth] & {WeightWidth{grant[i]}});
        end
        eff_weight_s = (sel_weight_s == '0) ? CreditOne : sel_weight_s;
    end

    // Next-state: credit reload/decrement and lock tracking on each transfer.
    always_comb begin
        xfer_s        = ready && (grant != '0);
        reload_s      = (grant != owner_r) || (credit_r == '0);
        last_s        = (grant & request_last) != '0;
        credit_base_s = reload_s ? eff_weight_s : credit_r;
        owner_n_s     = owner_r;
        credit_n_s    = credit_r;
        locked_n_s    = locked_r;
        abort_n_s     = 1'b0;
        if (xfer_s) begin
            owner_n_s = grant;
            if (last_s) begin
                credit_n_s = credit_base_s - CreditOne;
                locked_n_s = 1'b0;
            end else begin
                credit_n_s = credit_base_s;
                locked_n_s = 1'b1;
            end
        end else begin
`ifdef BR_ARB_WRR_BURST_ABORT_EN
            // Owner vanished mid-burst: drop the lock and forfeit the rest of its turn.
            if (locked_r && ((request & owner_r) == '0)) begin
                locked_n_s = 1'b0;
                credit_n_s = '0;
                abort_n_s  = 1'b1;
            end else begin
                abort_n_s  = 1'b0;
            end
`else
            abort_n_s = 1'b0;
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r  <= OwnerRst;
            credit_r <= '0;
            locked_r <= 1'b0;
            abort_r  <= 1'b0;
        end else begin
            owner_r  <= owner_n_s;
            credit_r <= credit_n_s;
            locked_r <= locked_n_s;
            abort_r  <= abort_n_s;
        end
    end

    assign owner  = owner_r;
    assign locked = locked_r;
    assign abort  = abort_r;

    br_arb_wrr_burst_chk #(
        .NumRequesters(NumRequesters)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .request (request),
        .grant   (grant),
        .locked  (locked_r),
        .owner   (owner_r)
    );

endmodule

// Protocol checks for the arbiter outputs.
module br_arb_wrr_burst_chk #(
    parameter int NumRequesters = 4
) (
    input logic                     clk,
    input logic                     rst,
    input logic [NumRequesters-1:0] request,
    input logic [NumRequesters-1:0] grant,
    input logic                     locked,
    input logic [NumRequesters-1:0] owner
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_subset_req: assert property (@(posedge clk) disable iff (rst) ((grant & ~request) == '0));
    a_grant_subset_owner: assert property (@(posedge clk) disable iff (rst)
        locked |-> ((grant & ~owner) == '0));
`ifndef BR_ARB_WRR_BURST_ABORT_EN
    // Without abort support the owner must keep requesting until its last beat.
    a_hold_request: assert property (@(posedge clk) disable iff (rst)
        locked |-> ((request & owner) != '0));
`endif

endmodule

// File: tb/tb_br_arb_wrr_burst.sv
// Directed self-checking bench for br_arb_wrr_burst (N=4, 4-bit weights).
module tb_br_arb_wrr_burst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  request = 4'b0000;
    logic [3:0]  request_last = 4'b0000;
    logic [15:0] weight = 16'h0000;
    logic        ready = 1'b0;
    logic [3:0]  grant;
    logic        locked;
    logic [3:0]  owner;
    logic        abort;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    br_arb_wrr_burst #(.NumRequesters(4), .WeightWidth(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .request      (request),
        .request_last (request_last),
        .weight       (weight),
        .ready        (ready),
        .grant        (grant),
        .locked       (locked),
        .owner        (owner),
        .abort        (abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        weight = 16'h0000;
        request = 4'b1111;
        request_last = 4'b1111;
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin $display("FAIL reset_grant got %b exp 0000", grant); errors++; end
        checks++;
        if (owner !== 4'b1000) begin $display("FAIL reset_owner got %b exp 1000", owner); errors++; end
        checks++;
        if (locked !== 1'b0 || abort !== 1'b0) begin
            $display("FAIL reset_flags got locked=%b abort=%b exp 0 0", locked, abort); errors++;
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (grant !== exp_g[k]) begin $display("FAIL rr_grant[%0d] got %b exp %b", k, grant, exp_g[k]); errors++; end
            checks++;
            if (locked !== 1'b0) begin $display("FAIL rr_locked[%0d] got %b exp 0", k, locked); errors++; end
            tick();
        end
    endtask

    task automatic test_wrr_weights();
        logic [3:0] exp_g [7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd2};
        request = 4'b1111;
        request_last = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (grant !== exp_g[k]) begin $display("FAIL wrr_grant[%0d] got %b exp %b", k, grant, exp_g[k]); errors++; end
            tick();
        end
        request = 4'b0000;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin $display("FAIL idle_grant got %b exp 0000", grant); errors++; end
        tick();
        checks++;
        if (owner !== 4'b0001 || locked !== 1'b0) begin
            $display("FAIL idle_hold got owner=%b locked=%b exp 0001 0", owner, locked); errors++;
        end
    endtask

    task automatic test_burst_lock();
        logic       rdy_v  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] last_v [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0010};
        logic [3:0] exp_g  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic       exp_l  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        request = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            ready = rdy_v[k];
            request_last = last_v[k];
            @(negedge clk);
            checks++;
            if (grant !== exp_g[k]) begin $display("FAIL burst_grant[%0d] got %b exp %b", k, grant, exp_g[k]); errors++; end
            checks++;
            if (locked !== exp_l[k]) begin $display("FAIL burst_locked[%0d] got %b exp %b", k, locked, exp_l[k]); errors++; end
            tick();
        end
    endtask

    task automatic test_weight_reload();
        logic [3:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
        request = 4'b0011;
        request_last = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (grant !== exp_g[k]) begin $display("FAIL reload_grant[%0d] got %b exp %b", k, grant, exp_g[k]); errors++; end
            tick();
            if (k == 0) weight = {4'd1, 4'd1, 4'd1, 4'd1};
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        request = 4'b0100;
        request_last = 4'b0000;
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100) begin $display("FAIL arst_first_grant got %b exp 0100", grant); errors++; end
        tick();
        @(negedge clk);
        checks++;
        if (locked !== 1'b1 || owner !== 4'b0100) begin
            $display("FAIL arst_locked got locked=%b owner=%b exp 1 0100", locked, owner); errors++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || owner !== 4'b1000 || grant !== 4'b0000) begin
            $display("FAIL arst_immediate got locked=%b owner=%b grant=%b exp 0 1000 0000", locked, owner, grant); errors++;
        end
        tick();
        request = 4'b1111;
        request_last = 4'b1111;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001) begin $display("FAIL arst_after_grant got %b exp 0001", grant); errors++; end
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        request = 4'b1100;
        request_last = 4'b0000;
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100) begin $display("FAIL abort_beat1_grant got %b exp 0100", grant); errors++; end
        tick();
`ifdef BR_ARB_WRR_BURST_ABORT_EN
        request = 4'b1000;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || locked !== 1'b1 || abort !== 1'b0) begin
            $display("FAIL abort_drop got grant=%b locked=%b abort=%b exp 0000 1 0", grant, locked, abort); errors++;
        end
        tick();
        request_last = 4'b1000;
        @(negedge clk);
        checks++;
        if (abort !== 1'b1 || locked !== 1'b0) begin
            $display("FAIL abort_pulse got abort=%b locked=%b exp 1 0", abort, locked); errors++;
        end
        checks++;
        if (grant !== 4'b1000) begin $display("FAIL abort_rotate got %b exp 1000", grant); errors++; end
        tick();
        @(negedge clk);
        checks++;
        if (abort !== 1'b0) begin $display("FAIL abort_single got %b exp 0", abort); errors++; end
`else
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100 || locked !== 1'b1 || abort !== 1'b0) begin
            $display("FAIL noabort_hold got grant=%b locked=%b abort=%b exp 0100 1 0", grant, locked, abort); errors++;
        end
        tick();
        ready = 1'b1;
        request_last = 4'b0100;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 4'b1000 || locked !== 1'b0 || abort !== 1'b0) begin
            $display("FAIL noabort_end got grant=%b locked=%b abort=%b exp 1000 0 0", grant, locked, abort); errors++;
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_wrr_weights();
        test_burst_lock();
        test_weight_reload();
        test_async_reset();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
